// File: rtl/switch_fabric_pkg.sv
// Shared constants and types for the 8x8 registered crossbar.
package switch_fabric_pkg;

  localparam int unsigned NUM_PORTS  = 8;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned PORT_SEL_W = 3;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/switch_out_sel.sv
// Per-output request decode and lowest-index priority selection for one output port.
module switch_out_sel
  import switch_fabric_pkg::*;
#(
  parameter int unsigned PORT = 0
) (
  input  logic [NUM_PORTS-1:0]  grant,
  input  addr_t                 addr [NUM_PORTS],
  output logic [PORT_SEL_W-1:0] winner,
  output logic                  valid,
  output logic                  collision
);

  logic [NUM_PORTS-1:0] req_s;

  // Build the request vector; out-of-range destinations (MSB set) never match.
  always_comb begin
    req_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_s[i] = grant[i] && !addr[i][ADDR_W-1] &&
                 (addr[i][PORT_SEL_W-1:0] == PORT_SEL_W'(PORT));
    end
  end

  // Scan high to low so the lowest requesting index is the one left standing.
  always_comb begin
    winner = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_s[i]) begin
        winner = PORT_SEL_W'(i);
      end else begin
        winner = winner;
      end
    end
  end

  // More than one bit set means at least one loser was dropped.
  always_comb begin
    valid     = |req_s;
    collision = (req_s & (req_s - NUM_PORTS'(1))) != NUM_PORTS'(0);
  end

endmodule

// File: rtl/switch_fabric.sv
// 8x8 registered crossbar: granted words reach their destination output one cycle later.
module switch_fabric
  import switch_fabric_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  data_t                din [NUM_PORTS],
  input  addr_t                addr [NUM_PORTS],
  input  logic [NUM_PORTS-1:0] grant,
  output data_t                dout [NUM_PORTS],
  output logic [NUM_PORTS-1:0] dout_valid,
  output logic [NUM_PORTS-1:0] collision
);

  logic [PORT_SEL_W-1:0] winner_s [NUM_PORTS];
  logic [NUM_PORTS-1:0]  valid_s;
  logic [NUM_PORTS-1:0]  collision_s;

  data_t                 dout_r [NUM_PORTS];
  logic [NUM_PORTS-1:0]  dout_valid_r;
  logic [NUM_PORTS-1:0]  collision_r;

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_out_sel
    switch_out_sel #(.PORT(j)) u_out_sel (
      .grant     (grant),
      .addr      (addr),
      .winner    (winner_s[j]),
      .valid     (valid_s[j]),
      .collision (collision_s[j])
    );
  end

  // Output registers; idle outputs are zeroed rather than held.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        dout_r[j] <= '0;
      end
      dout_valid_r <= '0;
      collision_r  <= '0;
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (valid_s[j]) begin
          dout_r[j] <= din[winner_s[j]];
        end else begin
          dout_r[j] <= '0;
        end
      end
      dout_valid_r <= valid_s;
      collision_r  <= collision_s;
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign collision  = collision_r;

endmodule

// File: tb/tb_switch_fabric.sv
// Directed and randomized bench for switch_fabric against an input-ordered reference model.
module tb_switch_fabric;

  logic        clk;
  logic        rst;
  logic [31:0] din  [8];
  logic [3:0]  addr [8];
  logic [7:0]  grant;
  logic [31:0] dout [8];
  logic [7:0]  dout_valid;
  logic [7:0]  collision;

  logic [31:0] exp_dout [8];
  logic [7:0]  exp_valid;
  logic [7:0]  exp_coll;

  int checks   = 0;
  int failures = 0;

  switch_fabric dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .addr       (addr),
    .grant      (grant),
    .dout       (dout),
    .dout_valid (dout_valid),
    .collision  (collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Walk inputs in index order: the first claimant of an output owns it, later ones collide.
  function automatic void model(input bit r);
    exp_valid = 8'h00;
    exp_coll  = 8'h00;
    for (int j = 0; j < 8; j++) exp_dout[j] = 32'h0;
    if (!r) begin
      for (int i = 0; i < 8; i++) begin
        if (grant[i] && addr[i] < 4'd8) begin
          int d;
          d = int'(addr[i]);
          if (exp_valid[d]) begin
            exp_coll[d] = 1'b1;
          end else begin
            exp_valid[d] = 1'b1;
            exp_dout[d]  = din[i];
          end
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compute expectations from the current inputs, clock once, then compare.
  task automatic step(input bit r, input string tag);
    rst = r;
    model(r);
    @(posedge clk);
    #1;
    for (int j = 0; j < 8; j++) chk($sformatf("%s dout[%0d]", tag, j), dout[j], exp_dout[j]);
    chk({tag, " dout_valid"}, {24'h0, dout_valid}, {24'h0, exp_valid});
    chk({tag, " collision"},  {24'h0, collision},  {24'h0, exp_coll});
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 8; i++) begin
      din[i]  = $urandom;
      addr[i] = 4'($urandom_range(0, 15));
    end
    grant = 8'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    randomize_inputs();

    // Reset with random traffic present
    step(1'b1, "reset0");
    randomize_inputs();
    step(1'b1, "reset1");
    chk("reset dout_valid const", {24'h0, dout_valid}, 32'h0);

    // Single transfer to output 7
    for (int i = 0; i < 8; i++) begin
      addr[i] = 4'b0111;
      din[i]  = 32'h1000_0000 + 32'(i);
    end
    din[0] = 32'hFADE_BABE;
    grant  = 8'b0000_0001;
    step(1'b0, "single0");
    chk("single0 dout7", dout[7], 32'hFADE_BABE);
    chk("single0 valid", {24'h0, dout_valid}, 32'h80);
    din[7] = 32'hDEAD_BEEF;
    grant  = 8'b1000_0000;
    step(1'b0, "single7");
    chk("single7 dout7", dout[7], 32'hDEAD_BEEF);

    // Collisions on output 7
    din[1] = 32'hBABA_B00E;
    din[3] = 32'h0F0F_0F0F;
    grant  = 8'b0101_0010;
    step(1'b0, "coll0");
    chk("coll0 dout7", dout[7], 32'hBABA_B00E);
    chk("coll0 coll7", {31'h0, collision[7]}, 32'h1);
    grant = 8'b1000_1000;
    step(1'b0, "coll1");
    chk("coll1 dout7", dout[7], 32'h0F0F_0F0F);
    chk("coll1 coll7", {31'h0, collision[7]}, 32'h1);

    // Full permutation
    for (int i = 0; i < 8; i++) begin
      addr[i] = 4'(7 - i);
      din[i]  = $urandom;
    end
    grant = 8'hFF;
    step(1'b0, "perm");
    chk("perm valid", {24'h0, dout_valid}, 32'hFF);
    chk("perm dout0", dout[0], din[7]);

    // Out-of-range destination
    addr[2] = 4'b1010;
    grant   = 8'b0000_0100;
    step(1'b0, "badaddr");
    chk("badaddr valid", {24'h0, dout_valid}, 32'h0);

    // Transfer then idle
    addr[4] = 4'b0111;
    grant   = 8'b0001_0000;
    step(1'b0, "pre_idle");
    grant = 8'h00;
    randomize_inputs();
    grant = 8'h00;
    step(1'b0, "idle");
    chk("idle dout7", dout[7], 32'h0);

    // Reset wins over an in-flight transfer
    randomize_inputs();
    grant = 8'hFF;
    step(1'b1, "midreset");

    // Randomized traffic with occasional reset
    for (int n = 0; n < 300; n++) begin
      randomize_inputs();
      if (n % 3 == 0) begin
        for (int i = 0; i < 8; i++) addr[i] = 4'($urandom_range(0, 2));
      end
      step(($urandom_range(0, 15) == 0), $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
